// File: rtl/led_status_pkg.sv
// Shared types and pattern helpers for the LED run-control block.
package led_status_pkg;

  // Widest LED bank the pattern helpers can describe.
  localparam int unsigned MAX_LED_W = 64;

  typedef logic [MAX_LED_W-1:0] led_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Run pattern seed: pairs of lit LEDs, ...0011_0011.
  function automatic led_vec_t reload_pattern(input int unsigned led_w);
    led_vec_t p;
    p = '0;
    for (int unsigned i = 0; i < MAX_LED_W; i++) begin
      if ((i < led_w) && ((i % 4) < 2)) p[i] = 1'b1;
    end
    return p;
  endfunction

  // Pause pattern: even LEDs lit for phase 0, odd LEDs lit for phase 1.
  function automatic led_vec_t alt_pattern(input int unsigned led_w, input logic phase);
    led_vec_t p;
    p = '0;
    for (int unsigned i = 0; i < MAX_LED_W; i++) begin
      if ((i < led_w) && (i[0] == phase)) p[i] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/led_status_if.sv
// Control inputs and status outputs of the LED run-control block.
interface led_status_if #(
  parameter int unsigned LED_W = 18,
  parameter int unsigned CNT_W = 4
);

  logic             start;
  logic             pause;
  logic             in;
  logic [LED_W-1:0] ledr;
  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             done;

  // Board/datapath side: drives the level inputs, observes status.
  modport master (
    output start, pause, in,
    input  ledr, state, count, done
  );

  // Run-control block side.
  modport slave (
    input  start, pause, in,
    output ledr, state, count, done
  );

endinterface

// File: rtl/led_status_fsm_tick_prescaler.sv
// Free-running animation prescaler: tick is high while the counter sits at TICK_DIV-1.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count wraps at LAST; tick is registered so it tracks cnt_q == LAST.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    tick_d = (cnt_d == LAST);
  end

  // Counter and tick registers; with TICK_DIV=1 tick is high even in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= (TICK_DIV == 32'd1);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_status_fsm.sv
// Run-control FSM (IDLE/RUN/PAUSE/DONE), event counter and animated LED bank.
module led_status_fsm
  import led_status_pkg::*;
#(
  parameter int unsigned LED_W     = 18,
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter int unsigned COUNT_MAX = 9
) (
  input logic         clk,
  input logic         reset,
  led_status_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(COUNT_MAX + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(COUNT_MAX);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT_MAX - 1);
  localparam logic [LED_W-1:0] RELOAD   = LED_W'(reload_pattern(LED_W));

  // Event vector bit positions.
  localparam int unsigned EV_START = 2;
  localparam int unsigned EV_PAUSE = 1;
  localparam int unsigned EV_IN    = 0;

  if (LED_W < 4 || LED_W > MAX_LED_W) begin : g_bad_led_w
    $error("led_status_fsm: LED_W out of range");
  end
  if (TICK_DIV < 1 || COUNT_MAX < 1) begin : g_bad_div
    $error("led_status_fsm: TICK_DIV and COUNT_MAX must be at least 1");
  end

  logic [2:0]       ev_s_q, ev_h_q;
  logic [2:0]       rise_c;
  logic             start_rise_c, pause_rise_c, in_rise_c;
  logic             tick_c;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [LED_W-1:0] pattern_q, pattern_d;
  logic             phase_q, phase_d;
  logic             done_q, done_d;
  logic [LED_W-1:0] ledr_q, ledr_d;
  logic             restart_c, changed_c;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_c)
  );

  // Sample and history flops for the three level inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_s_q <= '0;
      ev_h_q <= '0;
    end else begin
      ev_s_q <= {bus.start, bus.pause, bus.in};
      ev_h_q <= ev_s_q;
    end
  end

  assign rise_c       = ev_s_q & ~ev_h_q;
  assign start_rise_c = rise_c[EV_START];
  assign pause_rise_c = rise_c[EV_PAUSE];
  assign in_rise_c    = rise_c[EV_IN];

  // State, count, animation and LED registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      pattern_q <= RELOAD;
      phase_q   <= 1'b0;
      done_q    <= 1'b0;
      ledr_q    <= '1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pattern_q <= pattern_d;
      phase_q   <= phase_d;
      done_q    <= done_d;
      ledr_q    <= ledr_d;
    end
  end

  // Next-state, count, animation and LED decode; one event per cycle, start > pause > in.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pattern_d = pattern_q;
    phase_d   = phase_q;
    done_d    = 1'b0;
    ledr_d    = '1;
    restart_c = 1'b0;
    changed_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_rise_c) restart_c = 1'b1;
      end
      ST_RUN: begin
        if (start_rise_c) begin
          restart_c = 1'b1;
        end else if (pause_rise_c) begin
          state_d   = ST_PAUSE;
          changed_c = 1'b1;
        end else if (in_rise_c) begin
          if (count_q == LAST_CNT) begin
            count_d   = MAX_CNT;
            state_d   = ST_DONE;
            done_d    = 1'b1;
            changed_c = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_PAUSE: begin
        if (start_rise_c) begin
          restart_c = 1'b1;
        end else if (pause_rise_c) begin
          state_d   = ST_RUN;
          changed_c = 1'b1;
        end
      end
      ST_DONE: begin
        if (start_rise_c) restart_c = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (restart_c) begin
      state_d   = ST_RUN;
      count_d   = '0;
      pattern_d = RELOAD;
    end

    // A tick that coincides with a state change or restart is dropped.
    if (restart_c || changed_c) begin
      phase_d = 1'b0;
    end else if (tick_c) begin
      phase_d = ~phase_q;
      if (state_q == ST_RUN) pattern_d = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
    end

    case (state_q)
      ST_IDLE:  ledr_d = '1;
      ST_RUN:   ledr_d = pattern_q;
      ST_PAUSE: ledr_d = LED_W'(alt_pattern(LED_W, phase_q));
      ST_DONE:  ledr_d = {LED_W{phase_q}};
      default:  ledr_d = '1;
    endcase
  end

  assign bus.ledr  = ledr_q;
  assign bus.state = state_q;
  assign bus.count = count_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_led_status_fsm.sv
// Scoreboard bench for led_status_fsm with LED_W=8, TICK_DIV=4, COUNT_MAX=3.
module tb_led_status_fsm;

  localparam int unsigned LED_W     = 8;
  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned COUNT_MAX = 3;
  localparam int unsigned CNT_W     = 2;

  localparam int SEL_LEDR  = 0;
  localparam int SEL_STATE = 1;
  localparam int SEL_COUNT = 2;
  localparam int SEL_DONE  = 3;

  typedef struct {
    int         at;
    int         sel;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  led_status_if #(.LED_W(LED_W), .CNT_W(CNT_W)) bus ();

  led_status_fsm #(
    .LED_W     (LED_W),
    .TICK_DIV  (TICK_DIV),
    .COUNT_MAX (COUNT_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Edges since the last reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SEL_LEDR:  return bus.ledr;
      SEL_STATE: return 8'(bus.state);
      SEL_COUNT: return 8'(bus.count);
      default:   return 8'(bus.done);
    endcase
  endfunction

  // Queue an expected value for the negedge after edge 'at'.
  task automatic expect_at(input int at, input int sel, input logic [7:0] v, input string name);
    exp_t e;
    string fld;
    case (sel)
      SEL_LEDR:  fld = "ledr";
      SEL_STATE: fld = "state";
      SEL_COUNT: fld = "count";
      default:   fld = "done";
    endcase
    e.at  = at;
    e.sel = sel;
    e.exp = v;
    e.tag = $sformatf("%s_%s@%0d", name, fld, at);
    if (at <= cyc) check_val({"sched_", e.tag}, 32'(at), 32'(cyc + 1));
    else sb_q.push_back(e);
  endtask

  // Pop and compare every expectation due at this edge count.
  always @(negedge clk) begin
    int i;
    if (reset) begin
      i = 0;
      while (i < sb_q.size()) begin
        if (sb_q[i].at == cyc) begin
          check_val(sb_q[i].tag, 32'(observe(sb_q[i].sel)), 32'(sb_q[i].exp));
          sb_q.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // One-cycle high pulse on the chosen inputs, launched at a negedge.
  task automatic pulse(input logic s, input logic p, input logic n);
    bus.start = s;
    bus.pause = p;
    bus.in    = n;
    @(negedge clk);
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.in    = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    check_val({name, "_ledr"},  32'(bus.ledr),  32'h0000_00FF);
    check_val({name, "_state"}, 32'(bus.state), 32'd0);
    check_val({name, "_count"}, 32'(bus.count), 32'd0);
    check_val({name, "_done"},  32'(bus.done),  32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.in    = 1'b0;

    // Reset and idle; pause/in events in IDLE are ignored.
    repeat (3) @(negedge clk);
    #1 check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      expect_at(c, SEL_LEDR,  8'hFF, "idle");
      expect_at(c, SEL_STATE, 8'd0,  "idle");
      expect_at(c, SEL_COUNT, 8'd0,  "idle");
    end
    wait_cyc(5);  pulse(1'b0, 1'b1, 1'b0);
    wait_cyc(10); pulse(1'b0, 1'b0, 1'b1);

    // Start and rotation: RUN at edge 23, ticks at edges 24, 28, 32, 36.
    wait_cyc(21);
    expect_at(22, SEL_STATE, 8'd0,  "start");
    expect_at(23, SEL_STATE, 8'd1,  "start");
    expect_at(23, SEL_COUNT, 8'd0,  "start");
    expect_at(23, SEL_LEDR,  8'hFF, "start");
    expect_at(24, SEL_LEDR,  8'h33, "rot");
    expect_at(25, SEL_LEDR,  8'h66, "rot");
    expect_at(28, SEL_LEDR,  8'h66, "rot");
    expect_at(29, SEL_LEDR,  8'hCC, "rot");
    expect_at(33, SEL_LEDR,  8'h99, "rot");
    expect_at(37, SEL_LEDR,  8'h33, "rot");
    pulse(1'b1, 1'b0, 1'b0);

    // One count event in RUN lands on a tick edge; rotation continues.
    wait_cyc(38);
    expect_at(39, SEL_COUNT, 8'd1 - 8'd1, "cnt");
    expect_at(40, SEL_COUNT, 8'd1,  "cnt");
    expect_at(41, SEL_LEDR,  8'h66, "cnt");
    expect_at(45, SEL_LEDR,  8'hCC, "cnt");
    pulse(1'b0, 1'b0, 1'b1);

    // Pause at ledr=0xCC, alternate 0x55/0xAA, in ignored, resume at 0xCC.
    wait_cyc(44);
    expect_at(45, SEL_STATE, 8'd1,  "pause");
    expect_at(46, SEL_STATE, 8'd2,  "pause");
    expect_at(46, SEL_LEDR,  8'hCC, "pause");
    expect_at(47, SEL_LEDR,  8'h55, "pause");
    expect_at(48, SEL_LEDR,  8'h55, "pause");
    expect_at(49, SEL_LEDR,  8'hAA, "pause");
    expect_at(53, SEL_LEDR,  8'h55, "pause");
    pulse(1'b0, 1'b1, 1'b0);
    wait_cyc(50);
    expect_at(52, SEL_STATE, 8'd2,  "pin");
    expect_at(53, SEL_COUNT, 8'd1,  "pin");
    pulse(1'b0, 1'b0, 1'b1);
    wait_cyc(54);
    expect_at(56, SEL_STATE, 8'd1,  "resume");
    expect_at(56, SEL_LEDR,  8'h55, "resume");
    expect_at(57, SEL_LEDR,  8'hCC, "resume");
    expect_at(57, SEL_COUNT, 8'd1,  "resume");
    expect_at(60, SEL_LEDR,  8'hCC, "resume");
    expect_at(61, SEL_LEDR,  8'h99, "resume");
    pulse(1'b0, 1'b1, 1'b0);

    // Restart on a tick edge: pattern reloads to 0x33 without rotating.
    wait_cyc(62);
    expect_at(63, SEL_COUNT, 8'd1,  "rsttick");
    expect_at(64, SEL_STATE, 8'd1,  "rsttick");
    expect_at(64, SEL_COUNT, 8'd0,  "rsttick");
    expect_at(64, SEL_LEDR,  8'h99, "rsttick");
    expect_at(65, SEL_LEDR,  8'h33, "rsttick");
    expect_at(68, SEL_LEDR,  8'h33, "rsttick");
    expect_at(69, SEL_LEDR,  8'h66, "rsttick");
    pulse(1'b1, 1'b0, 1'b0);

    // Completion: three events, done pulse, DONE blink, count saturates.
    wait_cyc(70);
    expect_at(72, SEL_COUNT, 8'd1,  "fin");
    pulse(1'b0, 1'b0, 1'b1);
    wait_cyc(73);
    expect_at(75, SEL_COUNT, 8'd2,  "fin");
    pulse(1'b0, 1'b0, 1'b1);
    wait_cyc(76);
    expect_at(77, SEL_DONE,  8'd0,  "fin");
    expect_at(78, SEL_COUNT, 8'd3,  "fin");
    expect_at(78, SEL_STATE, 8'd3,  "fin");
    expect_at(78, SEL_DONE,  8'd1,  "fin");
    expect_at(78, SEL_LEDR,  8'h99, "fin");
    expect_at(79, SEL_DONE,  8'd0,  "fin");
    expect_at(79, SEL_LEDR,  8'h00, "blink");
    expect_at(80, SEL_LEDR,  8'h00, "blink");
    expect_at(81, SEL_LEDR,  8'hFF, "blink");
    expect_at(82, SEL_DONE,  8'd0,  "blink");
    expect_at(85, SEL_LEDR,  8'h00, "blink");
    pulse(1'b0, 1'b0, 1'b1);
    wait_cyc(86);
    expect_at(88, SEL_DONE,  8'd0,  "sat");
    expect_at(89, SEL_DONE,  8'd0,  "sat");
    expect_at(89, SEL_COUNT, 8'd3,  "sat");
    expect_at(89, SEL_STATE, 8'd3,  "sat");
    pulse(1'b0, 1'b0, 1'b1);

    // Start and pause together in RUN with count=2: start wins.
    wait_cyc(90);
    expect_at(92, SEL_STATE, 8'd1,  "sim");
    expect_at(92, SEL_COUNT, 8'd0,  "sim");
    pulse(1'b1, 1'b0, 1'b0);
    wait_cyc(93);
    expect_at(95, SEL_COUNT, 8'd1,  "sim");
    pulse(1'b0, 1'b0, 1'b1);
    wait_cyc(96);
    expect_at(98, SEL_COUNT, 8'd2,  "sim");
    pulse(1'b0, 1'b0, 1'b1);
    wait_cyc(99);
    expect_at(101, SEL_STATE, 8'd1,  "both");
    expect_at(101, SEL_COUNT, 8'd0,  "both");
    expect_at(101, SEL_LEDR,  8'hCC, "both");
    expect_at(102, SEL_LEDR,  8'h33, "both");
    expect_at(102, SEL_STATE, 8'd1,  "both");
    pulse(1'b1, 1'b1, 1'b0);

    // Reset mid-PAUSE, then release with start already high.
    wait_cyc(103);
    expect_at(105, SEL_STATE, 8'd2, "prerst");
    pulse(1'b0, 1'b1, 1'b0);
    wait_cyc(107);
    #2 reset = 1'b0;
    bus.start = 1'b1;
    #1 check_reset_vals("async");
    expect_at(1, SEL_STATE, 8'd0,  "rel");
    expect_at(2, SEL_STATE, 8'd1,  "rel");
    expect_at(2, SEL_COUNT, 8'd0,  "rel");
    expect_at(2, SEL_LEDR,  8'hFF, "rel");
    expect_at(3, SEL_LEDR,  8'h33, "rel");
    expect_at(5, SEL_LEDR,  8'h66, "rel");
    expect_at(9, SEL_LEDR,  8'hCC, "rel");
    expect_at(12, SEL_STATE, 8'd1, "rel");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_cyc(10);
    bus.start = 1'b0;

    g = 0;
    while (sb_q.size() > 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_status_fsm.md
# led_status_fsm

Parametrised run-control state machine and LED pattern generator for the counter designs. It takes start/pause/count-event inputs from the board switches and the counter datapath, and tracks IDLE/RUN/PAUSE/DONE. It also counts events up to a programmable limit. It drives an LED bank with a per-state animated pattern, paced by an internal prescaler. It sits between the debounced user inputs and the LEDR pins, and replaces fixed-width, unclocked pattern decoding.

## Interface
- LED_W, 18, number of LED outputs (≥4)
- TICK_DIV, 25_000_000, clk cycles per animation tick (≥1)
- COUNT_MAX, 9, number of `in` events that ends a run (≥1)
- CNT_W, $clog2(COUNT_MAX+1), derived width of `count`
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  level input; rising edge starts or restarts a run
- pause  input  1  level input; rising edge toggles RUN/PAUSE
- in  input  1  level input; rising edge is one count event
- ledr  output  LED_W  registered LED pattern
- state  output  2  current state: IDLE=0, RUN=1, PAUSE=2, DONE=3
- count  output  CNT_W  events counted in the current run
- done  output  1  one-cycle pulse on entry to DONE

## Operation
- Each of `start`, `pause` and `in` passes through one sample flop and one history flop.
- A rise is detected when the sample flop is 1 and the history flop is 0.
- Only one event acts per cycle. Priority: start > pause > in.
- IDLE:
  - start rise → RUN, count=0, pattern reloaded.
  - Other events are ignored.
- RUN:
  - start rise → stays in RUN, count=0, pattern reloaded.
  - pause rise → PAUSE.
  - in rise with count < COUNT_MAX-1 → count+1.
  - in rise with count = COUNT_MAX-1 → count=COUNT_MAX, go to DONE, done=1 for one cycle.
- PAUSE:
  - pause rise → RUN with pattern and count retained.
  - start rise → RUN, count=0, pattern reloaded.
  - in is ignored.
- DONE:
  - start rise → RUN, count=0, pattern reloaded.
  - Other events are ignored.
  - count holds at COUNT_MAX and never wraps.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1; it is not reset by state changes.
  - `tick` asserts in the cycle the counter equals TICK_DIV-1.
  - With TICK_DIV=1, tick is high every cycle.
- Phase bit: toggles on tick. It clears to 0 on any state change or restart.
- Pattern register:
  - Reload value: bit i = 1 iff (i mod 4) < 2, i.e. …0011_0011.
  - In RUN, each tick rotates it left by 1; bit LED_W-1 wraps to bit 0.
  - It is frozen outside RUN.
- ledr per state:
  - IDLE: all ones.
  - RUN: the pattern register.
  - PAUSE: phase 0 → even bits set (…0101); phase 1 → odd bits set (…1010).
  - DONE: all bits equal phase, so the whole bank blinks.
- A tick in the same cycle as a state change or restart is ignored: the pattern is reloaded or retained, not rotated, and phase stays 0.

## Timing
- Input first seen high at edge N: sample flop at N, state/count change at N+1, ledr reflects the new state at N+2. done is high in the cycle after edge N+1.
- Tick effects: pattern/phase update at the edge ending the tick cycle; ledr updates one edge later.
- A level held high produces exactly one event. A new event needs the input low for at least one sampled cycle.
- Reset values (while reset=0):
  - state=IDLE, count=0, done=0.
  - ledr = all ones.
  - prescaler=0, phase=0, pattern=reload value.
  - Sample and history flops = 0.
- Reset mid-run aborts immediately to IDLE. The first clock after release behaves as IDLE with no pending edges.
- An input already high at reset release registers one rise two edges later.

## Structure
- Package `led_status_pkg`:
  - State enum (IDLE/RUN/PAUSE/DONE, 2-bit).
  - Functions `reload_pattern(LED_W)` and `alt_pattern(LED_W, phase)`.
- Sub-module `tick_prescaler`: parameter TICK_DIV; ports clk, reset, tick. It is instantiated once.
- Edge detection, FSM, count, phase, pattern and ledr registers stay in the top module.

## Test plan
All scenarios use LED_W=8, TICK_DIV=4, COUNT_MAX=3.
- Reset and idle: hold reset=0, then release → ledr=0xFF, state=0, count=0 for 20 cycles.
- Start and rotation: start pulse → state=1, ledr=0x33, then 0x66, 0xCC, 0x99, 0x33 on successive ticks, 4 cycles apart.
- Pause and resume: pause rise in RUN with ledr=0xCC → ledr alternates 0x55/0xAA every 4 cycles. A second pause rise → RUN, ledr resumes at 0xCC. in pulses during PAUSE leave count unchanged.
- Completion: three in pulses in RUN → count 1, 2, 3, done pulses once, state=3, ledr blinks 0x00/0xFF. A further in pulse leaves count=3.
- Simultaneous events: start and pause rise in the same cycle in RUN with count=2 → state=1, count=0, ledr=0x33. A start rise coinciding with a tick → ledr=0x33, not rotated.
- Reset mid-operation: assert reset in PAUSE → asynchronously state=0, ledr=0xFF, count=0. Release with start held high → RUN entered exactly once.
